// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-ported register file.
package reg_file_pkg;

  typedef enum logic {CLEAR, IDLE} rf_clear_state_e;

  function automatic int rf_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/reg_file_clear_fsm.sv
// Post-reset clear sequencer: walks every entry once, then reports ready.
//  state | meaning
//  CLEAR | zeroing entry[ptr] this cycle; writes from ports are dropped
//  IDLE  | clear finished, ready asserted, normal read/write operation
module reg_file_clear_fsm
  import reg_file_pkg::*;
#(
  parameter int addr_width_p = 6
) (
  input  logic                    clk,
  input  logic                    i_reset,
  output logic                    o_ready,
  output logic                    o_clear_en,
  output logic [addr_width_p-1:0] o_clear_addr
);

  localparam logic [addr_width_p-1:0] PTR_LAST = '1;

  rf_clear_state_e           r_state;
  rf_clear_state_e           w_state_nxt;
  logic [addr_width_p-1:0]   r_ptr;
  logic [addr_width_p-1:0]   w_ptr_nxt;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Terminal count is detected rather than relying on the pointer wrapping.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    o_ready     = 1'b0;
    o_clear_en  = 1'b0;
    case (r_state)
      CLEAR: begin
        o_clear_en = 1'b1;
        if (r_ptr == PTR_LAST) w_state_nxt = IDLE;
        else                   w_ptr_nxt   = r_ptr + 1'b1;
      end
      IDLE: o_ready = 1'b1;
    endcase
  end

  assign o_clear_addr = r_ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-ported register file: async reads, prioritised sync writes,
// optional write-to-read bypass and hardwired-zero entry 0.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int addr_width_p  = 6,
  parameter int data_width_p  = 32,
  parameter int read_ports_p  = 2,
  parameter int write_ports_p = 2,
  parameter int bypass_p      = 1,
  parameter int zero_reg_p    = 0
) (
  input  logic                                   clk,
  input  logic                                   reset_i,
  input  logic [read_ports_p*addr_width_p-1:0]   rd_addr_i,
  output logic [read_ports_p*data_width_p-1:0]   rd_data_o,
  input  logic [write_ports_p-1:0]               wen_i,
  input  logic [write_ports_p*addr_width_p-1:0]  wr_addr_i,
  input  logic [write_ports_p*data_width_p-1:0]  wr_data_i,
  output logic                                   ready_o
);

  localparam int A     = addr_width_p;
  localparam int D     = data_width_p;
  localparam int DEPTH = rf_depth(addr_width_p);

  logic [D-1:0]  r_mem [DEPTH];
  logic          w_ready;
  logic          w_clear_en;
  logic [A-1:0]  w_clear_addr;
  logic [read_ports_p*D-1:0] w_rd_data;

  reg_file_clear_fsm #(
    .addr_width_p (addr_width_p)
  ) u_clear_fsm (
    .clk          (clk),
    .i_reset      (reset_i),
    .o_ready      (w_ready),
    .o_clear_en   (w_clear_en),
    .o_clear_addr (w_clear_addr)
  );

  // Ascending port loop: the last non-blocking write wins, giving the
  // highest-indexed port priority on an address conflict.
  always_ff @(posedge clk) begin
    if (w_clear_en) begin
      r_mem[w_clear_addr] <= '0;
    end else if (w_ready) begin
      for (int p = 0; p < write_ports_p; p++) begin
        if (wen_i[p] && !(zero_reg_p != 0 && wr_addr_i[p*A +: A] == '0))
          r_mem[wr_addr_i[p*A +: A]] <= wr_data_i[p*D +: D];
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int k = 0; k < read_ports_p; k++) begin
      if (w_ready && !(zero_reg_p != 0 && rd_addr_i[k*A +: A] == '0)) begin
        w_rd_data[k*D +: D] = r_mem[rd_addr_i[k*A +: A]];
        if (bypass_p != 0) begin
          for (int p = 0; p < write_ports_p; p++) begin
            if (wen_i[p] && wr_addr_i[p*A +: A] == rd_addr_i[k*A +: A])
              w_rd_data[k*D +: D] = wr_data_i[p*D +: D];
          end
        end
      end
    end
  end

  assign rd_data_o = w_rd_data;
  assign ready_o   = w_ready;

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised bench for reg_file_mp: three configurations share one stimulus
// stream and are checked every cycle against a behavioural array model.
module tb_reg_file_mp;

  localparam int A     = 6;
  localparam int D     = 32;
  localparam int R     = 2;
  localparam int W     = 2;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_i;
  logic [W-1:0]     wen_i;
  logic [W*A-1:0]   wr_addr_i;
  logic [W*D-1:0]   wr_data_i;
  logic [R*A-1:0]   rd_addr_i;
  logic [R*D-1:0]   rd_b, rd_n, rd_z;
  logic             rdy_b, rdy_n, rdy_z;

  int checks   = 0;
  int failures = 0;

  reg_file_mp #(.addr_width_p(A), .data_width_p(D), .read_ports_p(R), .write_ports_p(W),
                .bypass_p(1), .zero_reg_p(0)) dut_b (
    .clk(clk), .reset_i(reset_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_b),
    .wen_i(wen_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .ready_o(rdy_b));

  reg_file_mp #(.addr_width_p(A), .data_width_p(D), .read_ports_p(R), .write_ports_p(W),
                .bypass_p(0), .zero_reg_p(0)) dut_n (
    .clk(clk), .reset_i(reset_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_n),
    .wen_i(wen_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .ready_o(rdy_n));

  reg_file_mp #(.addr_width_p(A), .data_width_p(D), .read_ports_p(R), .write_ports_p(W),
                .bypass_p(1), .zero_reg_p(1)) dut_z (
    .clk(clk), .reset_i(reset_i), .rd_addr_i(rd_addr_i), .rd_data_o(rd_z),
    .wen_i(wen_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .ready_o(rdy_z));

  // Model: a reset makes the array read as all-zero and blocks writes for
  // DEPTH cycles; reads are forced to zero during that window anyway.
  logic [D-1:0] m_mem [DEPTH];
  int           m_clear_left = 0;
  bit           m_init = 1'b0;

  always @(posedge clk) begin
    if (reset_i) begin
      m_init       = 1'b1;
      m_clear_left = DEPTH;
      foreach (m_mem[i]) m_mem[i] = '0;
    end else if (m_clear_left > 0) begin
      m_clear_left--;
    end else begin
      for (int p = 0; p < W; p++)
        if (wen_i[p]) m_mem[wr_addr_i[p*A +: A]] = wr_data_i[p*D +: D];
    end
  end

  function automatic logic [D-1:0] exp_rd(input int k, input bit byp, input bit zr);
    logic [A-1:0] a;
    a = rd_addr_i[k*A +: A];
    if (!(m_init && m_clear_left == 0)) return '0;
    if (zr && a == '0) return '0;
    if (byp)
      for (int p = W-1; p >= 0; p--)
        if (wen_i[p] && wr_addr_i[p*A +: A] == a) return wr_data_i[p*D +: D];
    return m_mem[a];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      check("ready_byp",   64'(rdy_b), 64'(m_clear_left == 0));
      check("ready_nobyp", 64'(rdy_n), 64'(m_clear_left == 0));
      check("ready_zero",  64'(rdy_z), 64'(m_clear_left == 0));
      for (int k = 0; k < R; k++) begin
        check("rd_byp",   64'(rd_b[k*D +: D]), 64'(exp_rd(k, 1'b1, 1'b0)));
        check("rd_nobyp", 64'(rd_n[k*D +: D]), 64'(exp_rd(k, 1'b0, 1'b0)));
        check("rd_zero",  64'(rd_z[k*D +: D]), 64'(exp_rd(k, 1'b1, 1'b1)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with ready low after a reset edge; bounded.
  task automatic count_clear(output int n);
    n = 0;
    @(negedge clk);
    while (!rdy_b && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    reset_i   = 1'b1;
    wen_i     = '0;
    wr_addr_i = '0;
    wr_data_i = '0;
    rd_addr_i = '0;
    tick();
    reset_i = 1'b0;
    count_clear(n);
    check("init_clear_len", 64'(n), 64'd64);

    // Preload every entry with all-ones
    tick();
    for (int a = 0; a < DEPTH; a += 2) begin
      wen_i     = 2'b11;
      wr_addr_i = {6'(a + 1), 6'(a)};
      wr_data_i = '1;
      tick();
    end
    wen_i = '0;
    rd_addr_i = {6'd63, 6'd0};
    #1;
    check("preload_p0", 64'(rd_n[31:0]),  64'hFFFF_FFFF);
    check("preload_p1", 64'(rd_n[63:32]), 64'hFFFF_FFFF);

    // Reset pulse with a write held throughout the clear
    reset_i = 1'b1;
    tick();
    reset_i   = 1'b0;
    wen_i     = 2'b01;
    wr_addr_i = {6'd0, 6'd10};
    wr_data_i = {32'h0, 32'h0000_0BAD};
    count_clear(n);
    wen_i = '0;
    check("clear_len", 64'(n), 64'd64);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr_i = {6'(DEPTH - 1 - a), 6'(a)};
      #1;
      check("cleared_entry", 64'(rd_n[31:0]), 64'h0);
    end

    // Basic write then read
    tick();
    wen_i     = 2'b01;
    wr_addr_i = {6'd0, 6'd5};
    wr_data_i = {32'h0, 32'hDEAD_BEEF};
    rd_addr_i = {6'd6, 6'd5};
    tick();
    wen_i = '0;
    #1;
    check("basic_p0", 64'(rd_n[31:0]),  64'hDEAD_BEEF);
    check("basic_p1", 64'(rd_n[63:32]), 64'h0);

    // Conflict on one address, then two distinct addresses
    wen_i     = 2'b11;
    wr_addr_i = {6'd9, 6'd9};
    wr_data_i = {32'h2, 32'h1};
    rd_addr_i = {6'd9, 6'd9};
    #1;
    check("conflict_bypass", 64'(rd_b[31:0]), 64'h2);
    tick();
    wen_i = '0;
    #1;
    check("conflict_p0", 64'(rd_n[31:0]),  64'h2);
    check("conflict_p1", 64'(rd_n[63:32]), 64'h2);
    wen_i     = 2'b11;
    wr_addr_i = {6'd4, 6'd3};
    wr_data_i = {32'h44, 32'h33};
    rd_addr_i = {6'd4, 6'd3};
    tick();
    wen_i = '0;
    #1;
    check("dual_wr_3", 64'(rd_n[31:0]),  64'h33);
    check("dual_wr_4", 64'(rd_n[63:32]), 64'h44);

    // Bypass versus no bypass
    wen_i     = 2'b01;
    wr_addr_i = {6'd0, 6'd7};
    wr_data_i = {32'h0, 32'h0000_A5A5};
    rd_addr_i = {6'd7, 6'd7};
    #1;
    check("bypass_same", 64'(rd_b[31:0]), 64'hA5A5);
    check("nobypass_old", 64'(rd_n[31:0]), 64'h0);
    tick();
    wen_i = '0;
    #1;
    check("nobypass_next", 64'(rd_n[31:0]), 64'hA5A5);

    // Hardwired zero entry
    wen_i     = 2'b01;
    wr_addr_i = {6'd0, 6'd0};
    wr_data_i = {32'h0, 32'h0000_1234};
    rd_addr_i = {6'd0, 6'd0};
    #1;
    check("zero_same", 64'(rd_z[31:0]), 64'h0);
    check("zero_ref_bypass", 64'(rd_b[31:0]), 64'h1234);
    tick();
    wen_i = '0;
    #1;
    check("zero_next_p0", 64'(rd_z[31:0]),  64'h0);
    check("zero_next_p1", 64'(rd_z[63:32]), 64'h0);
    check("zero_ref_next", 64'(rd_b[31:0]), 64'h1234);

    // Reset mid-clear restarts the full sequence
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    repeat (20) @(negedge clk);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    count_clear(n);
    check("midclear_len", 64'(n), 64'd64);
    rd_addr_i = {6'd7, 6'd5};
    #1;
    check("midclear_entry5", 64'(rd_n[31:0]),  64'h0);
    check("midclear_entry7", 64'(rd_n[63:32]), 64'h0);

    // Random traffic, occasional resets, frequent address collisions
    tick();
    for (int i = 0; i < 3000; i++) begin
      reset_i = ($urandom_range(0, 399) == 0);
      wen_i   = W'($urandom);
      for (int p = 0; p < W; p++) begin
        wr_addr_i[p*A +: A] = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7))
                                                          : 6'($urandom);
        wr_data_i[p*D +: D] = $urandom;
      end
      for (int k = 0; k < R; k++)
        rd_addr_i[k*A +: A] = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7))
                                                          : 6'($urandom);
      tick();
    end
    reset_i = 1'b0;
    wen_i   = '0;
    tick();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
